// File: rtl/chess_clock_pkg.sv
// Shared types and constants for the two-player chess clock core.
// The BCD conversion helper is evaluated at elaboration time only.
package chess_clock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN_A,
    RUN_B,
    PAUSED,
    FLAG
  } state_t;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX    = 4'd9;

  typedef struct packed {
    logic [DIGIT_W-1:0] min_tens;
    logic [DIGIT_W-1:0] min_ones;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] sec_ones;
  } mmss_t;

  function automatic mmss_t to_bcd_mmss(input int minutes, input int seconds);
    mmss_t r;
    r.min_tens = DIGIT_W'(minutes / 10);
    r.min_ones = DIGIT_W'(minutes % 10);
    r.sec_tens = DIGIT_W'(seconds / 10);
    r.sec_ones = DIGIT_W'(seconds % 10);
    return r;
  endfunction

endpackage

// File: rtl/chess_clock_core_if.sv
// Control pulses into the chess clock and the display/status bundle out of it.
interface chess_clock_core_if;
  import chess_clock_pkg::*;

  logic               start;
  logic               switch_turn;
  logic               pause;
  logic [DIGIT_W-1:0] min_tens;
  logic [DIGIT_W-1:0] min_ones;
  logic [DIGIT_W-1:0] sec_tens;
  logic [DIGIT_W-1:0] sec_ones;
  logic               active_b;
  logic               running;
  logic               flag_a;
  logic               flag_b;

  modport master (
    output start, switch_turn, pause,
    input  min_tens, min_ones, sec_tens, sec_ones,
    input  active_b, running, flag_a, flag_b
  );

  modport slave (
    input  start, switch_turn, pause,
    output min_tens, min_ones, sec_tens, sec_ones,
    output active_b, running, flag_a, flag_b
  );

endinterface

// File: rtl/chess_clock_core_bcd_mmss_down.sv
// One player's MM:SS BCD down-counter; loads on clr, saturates at 00:00.
module bcd_mmss_down
  import chess_clock_pkg::*;
(
  input  logic               clk,
  input  logic               clr,
  input  mmss_t              load_val,
  input  logic               dec,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               is_zero
);

  mmss_t t;
  mmss_t t_dec;

  assign is_zero = (t == '0);

  // Borrow ripples right-to-left; the caller never decrements past 00:00.
  always_comb begin
    t_dec = t;
    if (t.sec_ones != '0) begin
      t_dec.sec_ones = t.sec_ones - 4'd1;
    end else begin
      t_dec.sec_ones = DIGIT_MAX;
      if (t.sec_tens != '0) begin
        t_dec.sec_tens = t.sec_tens - 4'd1;
      end else begin
        t_dec.sec_tens = SEC_TENS_MAX;
        if (t.min_ones != '0) begin
          t_dec.min_ones = t.min_ones - 4'd1;
        end else begin
          t_dec.min_ones = DIGIT_MAX;
          t_dec.min_tens = t.min_tens - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      t <= load_val;
    end else if (dec && !is_zero) begin
      t <= t_dec;
    end
  end

  assign min_tens = t.min_tens;
  assign min_ones = t.min_ones;
  assign sec_tens = t.sec_tens;
  assign sec_ones = t.sec_ones;

endmodule

// File: rtl/chess_clock_core.sv
// Two-player chess clock: turn FSM, 1 s prescaler, per-player BCD timers
// and the display mux feeding the seven-segment multiplexer.
module chess_clock_core
  import chess_clock_pkg::*;
#(
  parameter int TICK_DIV = 100000000,
  parameter int INIT_MIN = 5,
  parameter int INIT_SEC = 0
) (
  input logic clk,
  input logic clr,
  chess_clock_core_if.slave bus
);

  if (TICK_DIV < 2) begin : g_bad_div
    $error("chess_clock_core: TICK_DIV must be at least 2");
  end
  if (INIT_MIN < 0 || INIT_MIN > 99 || INIT_SEC < 0 || INIT_SEC > 59) begin : g_bad_range
    $error("chess_clock_core: INIT_MIN/INIT_SEC out of range");
  end
  if (INIT_MIN == 0 && INIT_SEC == 0) begin : g_bad_init
    $error("chess_clock_core: starting time of 00:00 is not allowed");
  end

  localparam mmss_t INIT_VAL = to_bcd_mmss(INIT_MIN, INIT_SEC);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST_COUNT = PW'(TICK_DIV - 1);

  state_t        state, state_n;
  logic [PW-1:0] prescaler, prescaler_n;
  logic          active_b, active_b_n;
  logic          flag_a, flag_a_n;
  logic          flag_b, flag_b_n;
  logic          run_state;
  logic          tick;
  logic          dec_a, dec_b;

  logic [DIGIT_W-1:0] a_mt, a_mo, a_st, a_so;
  logic [DIGIT_W-1:0] b_mt, b_mo, b_st, b_so;
  logic               a_zero, b_zero;
  logic               a_one, b_one;

  assign run_state = (state == RUN_A) || (state == RUN_B);
  assign tick      = run_state && (prescaler == LAST_COUNT);
  assign dec_a     = tick && (state == RUN_A);
  assign dec_b     = tick && (state == RUN_B);
  assign a_one     = (a_mt == '0) && (a_mo == '0) && (a_st == '0) && (a_so == 4'd1);
  assign b_one     = (b_mt == '0) && (b_mo == '0) && (b_st == '0) && (b_so == 4'd1);

  bcd_mmss_down u_timer_a (
    .clk      (clk),
    .clr      (clr),
    .load_val (INIT_VAL),
    .dec      (dec_a),
    .min_tens (a_mt),
    .min_ones (a_mo),
    .sec_tens (a_st),
    .sec_ones (a_so),
    .is_zero  (a_zero)
  );

  bcd_mmss_down u_timer_b (
    .clk      (clk),
    .clr      (clr),
    .load_val (INIT_VAL),
    .dec      (dec_b),
    .min_tens (b_mt),
    .min_ones (b_mo),
    .sec_tens (b_st),
    .sec_ones (b_so),
    .is_zero  (b_zero)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      prescaler <= '0;
      active_b  <= 1'b0;
      flag_a    <= 1'b0;
      flag_b    <= 1'b0;
    end else begin
      state     <= state_n;
      prescaler <= prescaler_n;
      active_b  <= active_b_n;
      flag_a    <= flag_a_n;
      flag_b    <= flag_b_n;
    end
  end

  // Timeout outranks pause, and pause outranks a turn switch.
  always_comb begin
    state_n     = state;
    prescaler_n = prescaler;
    active_b_n  = active_b;
    flag_a_n    = flag_a;
    flag_b_n    = flag_b;

    if (run_state) begin
      prescaler_n = tick ? '0 : prescaler + PW'(1);
    end

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_n    = RUN_A;
          active_b_n = 1'b0;
        end
      end
      RUN_A: begin
        if (a_zero || (tick && a_one)) begin
          state_n  = FLAG;
          flag_a_n = 1'b1;
        end else if (bus.pause) begin
          state_n = PAUSED;
        end else if (bus.switch_turn) begin
          state_n     = RUN_B;
          active_b_n  = 1'b1;
          prescaler_n = '0;
        end
      end
      RUN_B: begin
        if (b_zero || (tick && b_one)) begin
          state_n  = FLAG;
          flag_b_n = 1'b1;
        end else if (bus.pause) begin
          state_n = PAUSED;
        end else if (bus.switch_turn) begin
          state_n     = RUN_A;
          active_b_n  = 1'b0;
          prescaler_n = '0;
        end
      end
      PAUSED: begin
        if (bus.pause) begin
          state_n = active_b ? RUN_B : RUN_A;
        end
      end
      FLAG: begin
        state_n = FLAG;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.min_tens = active_b ? b_mt : a_mt;
  assign bus.min_ones = active_b ? b_mo : a_mo;
  assign bus.sec_tens = active_b ? b_st : a_st;
  assign bus.sec_ones = active_b ? b_so : a_so;
  assign bus.active_b = active_b;
  assign bus.running  = run_state;
  assign bus.flag_a   = flag_a;
  assign bus.flag_b   = flag_b;

endmodule

// File: tb/tb_chess_clock_core.sv
// Scoreboard bench for chess_clock_core: every output change is matched
// against a queue of expected display/status snapshots and their edge numbers.
module tb_chess_clock_core;

  typedef struct {
    string       name;
    logic [15:0] digits;
    logic        ab;
    logic        run;
    logic        fa;
    logic        fb;
    int          cyc;
  } exp_t;

  logic clk;
  logic clr;
  int   edge_cnt;
  int   checks;
  int   failures;
  exp_t exp_q[$];

  chess_clock_core_if bus ();

  chess_clock_core #(
    .TICK_DIV (4),
    .INIT_MIN (5),
    .INIT_SEC (0)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached at edge %0d, required finish earlier", edge_cnt);
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [15:0] bcd_of(input int secs);
    int m, s;
    logic [15:0] r;
    m = secs / 60;
    s = secs % 60;
    r[15:12] = 4'(m / 10);
    r[11:8]  = 4'(m % 10);
    r[7:4]   = 4'(s / 10);
    r[3:0]   = 4'(s % 10);
    return r;
  endfunction

  task automatic push_exp(input string name, input logic [15:0] digits,
                          input logic ab, input logic run, input logic fa,
                          input logic fb, input int cyc);
    exp_t e;
    e.name = name; e.digits = digits; e.ab = ab; e.run = run;
    e.fa = fa; e.fb = fb; e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic wait_to(input int e);
    while (edge_cnt < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds the given pulses for exactly one sampling edge.
  task automatic applyStimulus(input logic s, input logic sw, input logic p, input logic c);
    bus.start       = s;
    bus.switch_turn = sw;
    bus.pause       = p;
    clr             = c;
    @(posedge clk);
    #1;
    bus.start       = 1'b0;
    bus.switch_turn = 1'b0;
    bus.pause       = 1'b0;
    clr             = 1'b0;
  endtask

  task automatic checkOutput(input exp_t e, input logic [19:0] snap, input int cyc);
    logic [19:0] want;
    want = {e.digits, e.ab, e.run, e.fa, e.fb};
    checks++;
    if (snap !== want || cyc != e.cyc) begin
      failures++;
      $display("[TB] FAIL %s: got digits=%h ab=%b run=%b fa=%b fb=%b at edge %0d, required digits=%h ab=%b run=%b fa=%b fb=%b at edge %0d",
               e.name, snap[19:4], snap[3], snap[2], snap[1], snap[0], cyc,
               e.digits, e.ab, e.run, e.fa, e.fb, e.cyc);
    end
  endtask

  // Monitor: any change of the output bundle is a DUT response.
  initial begin
    logic [19:0] prev;
    logic [19:0] snap;
    exp_t        e;
    prev = 'x;
    forever begin
      @(negedge clk);
      snap = {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones,
              bus.active_b, bus.running, bus.flag_a, bus.flag_b};
      if (snap !== prev) begin
        prev = snap;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_change: got digits=%h ab=%b run=%b fa=%b fb=%b at edge %0d, required no change",
                   snap[19:4], snap[3], snap[2], snap[1], snap[0], edge_cnt);
        end else begin
          e = exp_q.pop_front();
          checkOutput(e, snap, edge_cnt);
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc < edge_cnt) begin
        e = exp_q.pop_front();
        checks++;
        failures++;
        $display("[TB] FAIL %s: got no change by edge %0d, required digits=%h ab=%b run=%b fa=%b fb=%b at edge %0d",
                 e.name, edge_cnt, e.digits, e.ab, e.run, e.fa, e.fb, e.cyc);
      end
    end
  end

  initial begin
    int r, s, c;
    checks          = 0;
    failures        = 0;
    bus.start       = 1'b0;
    bus.switch_turn = 1'b0;
    bus.pause       = 1'b0;
    clr             = 1'b1;
    push_exp("reset", 16'h0500, 0, 0, 0, 0, 1);
    wait_to(3);
    clr = 1'b0;

    // Idle: pause/switch ignored, no decrement.
    wait_to(8);
    applyStimulus(0, 1, 1, 0);
    wait_to(12);
    applyStimulus(0, 0, 1, 0);
    wait_to(23);

    // Start and borrow 5:00 -> 4:59.
    applyStimulus(1, 0, 0, 0);
    r = edge_cnt;
    push_exp("start_run", 16'h0500, 0, 1, 0, 0, r);
    push_exp("a_459", 16'h0459, 0, 1, 0, 0, r + 4);
    push_exp("a_458", 16'h0458, 0, 1, 0, 0, r + 8);
    push_exp("a_457", 16'h0457, 0, 1, 0, 0, r + 12);

    // Turn switching.
    wait_to(r + 12);
    applyStimulus(0, 1, 0, 0);
    push_exp("switch_to_b", 16'h0500, 1, 1, 0, 0, r + 13);
    push_exp("b_459", 16'h0459, 1, 1, 0, 0, r + 17);
    push_exp("b_458", 16'h0458, 1, 1, 0, 0, r + 21);
    wait_to(r + 21);
    applyStimulus(0, 1, 0, 0);
    push_exp("switch_to_a", 16'h0457, 0, 1, 0, 0, r + 22);
    push_exp("a_456", 16'h0456, 0, 1, 0, 0, r + 26);

    // Pause keeps the partial second; switch/start ignored while paused.
    wait_to(r + 27);
    applyStimulus(0, 0, 1, 0);
    push_exp("paused", 16'h0456, 0, 0, 0, 0, r + 28);
    wait_to(r + 40);
    applyStimulus(0, 1, 0, 0);
    wait_to(r + 50);
    applyStimulus(1, 0, 0, 0);
    wait_to(r + 68);
    applyStimulus(0, 0, 1, 0);
    push_exp("resume", 16'h0456, 0, 1, 0, 0, r + 69);
    push_exp("a_455_two_later", 16'h0455, 0, 1, 0, 0, r + 71);

    // Pause and switch together: pause wins.
    wait_to(r + 72);
    applyStimulus(0, 1, 1, 0);
    push_exp("pause_beats_switch", 16'h0455, 0, 0, 0, 0, r + 73);
    wait_to(r + 80);
    applyStimulus(0, 0, 1, 0);
    push_exp("resume2", 16'h0455, 0, 1, 0, 0, r + 81);
    push_exp("a_454", 16'h0454, 0, 1, 0, 0, r + 83);

    // B runs down to 3:12, then clr mid-run with other inputs asserted.
    wait_to(r + 84);
    applyStimulus(0, 1, 0, 0);
    push_exp("switch_to_b2", 16'h0458, 1, 1, 0, 0, r + 85);
    for (int n = 1; n <= 106; n++) begin
      push_exp("b_count", bcd_of(298 - n), 1, 1, 0, 0, r + 85 + 4 * n);
    end
    wait_to(r + 510);
    applyStimulus(1, 0, 1, 1);
    push_exp("clr_mid_run", 16'h0500, 0, 0, 0, 0, r + 511);

    // Full countdown of A to a flag; FLAG ignores every pulse.
    c = edge_cnt;
    wait_to(c + 5);
    applyStimulus(0, 1, 0, 0);
    wait_to(c + 10);
    applyStimulus(1, 0, 0, 0);
    s = edge_cnt;
    push_exp("start2", 16'h0500, 0, 1, 0, 0, s);
    for (int n = 1; n <= 299; n++) begin
      push_exp("a_count", bcd_of(300 - n), 0, 1, 0, 0, s + 4 * n);
    end
    push_exp("flag_a", 16'h0000, 0, 0, 1, 0, s + 1200);
    wait_to(s + 1210);
    applyStimulus(1, 1, 1, 0);
    wait_to(s + 1250);

    // Switch on the final tick: flag wins, switch discarded.
    applyStimulus(0, 0, 0, 1);
    c = edge_cnt;
    push_exp("clr_from_flag", 16'h0500, 0, 0, 0, 0, c);
    wait_to(c + 2);
    applyStimulus(1, 0, 0, 0);
    s = edge_cnt;
    push_exp("start3", 16'h0500, 0, 1, 0, 0, s);
    for (int n = 1; n <= 299; n++) begin
      push_exp("a_count2", bcd_of(300 - n), 0, 1, 0, 0, s + 4 * n);
    end
    wait_to(s + 1199);
    applyStimulus(0, 1, 0, 0);
    push_exp("flag_beats_switch", 16'h0000, 0, 0, 1, 0, s + 1200);
    wait_to(s + 1220);

    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
